// File: rtl/ft_pkg.sv
// Shared definitions for the lockstep fault-tolerance blocks: recovery FSM states and
// default register-file geometry.
package ft_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHalt,
    StRestore,
    StDone
  } rf_rec_state_e;

  localparam int unsigned AddrWidthDef   = 5;
  localparam int unsigned DataWidthDef   = 32;
  localparam int unsigned ErrCntWidthDef = 8;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the register file: one write port, one combinational read port,
// asynchronous clear. Entry 0 is hardwired to zero.
module shadow_regfile #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : mem_q[raddr_i];

endmodule

// File: rtl/rf_recovery_ctrl.sv
// Lockstep register-file recovery: shadows agreed writes and, on a comparator mismatch,
// halts both cores and replays the whole shadow into their register files.
module rf_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = AddrWidthDef,
  parameter int unsigned DATA_WIDTH    = DataWidthDef,
  parameter int unsigned ERR_CNT_WIDTH = ErrCntWidthDef
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     error_i,
  output logic                     halt_o,
  output logic                     restore_we_o,
  output logic [ADDR_WIDTH-1:0]    restore_addr_o,
  output logic [DATA_WIDTH-1:0]    restore_data_o,
  output logic                     recovery_done_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  rf_rec_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  shadow_we;

  // A mismatching cycle never commits, and nothing commits while recovering.
  assign shadow_we = (state_q == StIdle) && we_i && !error_i;

  shadow_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shadow (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (shadow_we),
    .waddr_i (addr_i),
    .wdata_i (data_i),
    .raddr_i (cnt_d),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (error_i) state_d = StHalt;
      end
      StHalt: begin
        state_d = StRestore;
        cnt_d   = '0;
      end
      StRestore: begin
        if (cnt_q == LastAddr) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      halt_o          <= 1'b0;
      restore_we_o    <= 1'b0;
      restore_addr_o  <= '0;
      restore_data_o  <= '0;
      recovery_done_o <= 1'b0;
      err_count_o     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      halt_o          <= (state_d != StIdle);
      restore_we_o    <= (state_d == StRestore);
      restore_addr_o  <= (state_d == StRestore) ? cnt_d : '0;
      restore_data_o  <= (state_d == StRestore) ? rd_data : '0;
      recovery_done_o <= (state_d == StDone);
      if ((state_q == StIdle) && error_i && (err_count_o != '1)) begin
        err_count_o <= err_count_o + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_recovery_ctrl.sv
// Scoreboard bench for rf_recovery_ctrl: stimulus queues expected restore beats,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_rf_recovery_ctrl;

  localparam int unsigned Aw = 5;
  localparam int unsigned Dw = 32;
  localparam int unsigned Ew = 8;

  typedef struct packed {
    logic          done;
    logic [Aw-1:0] addr;
    logic [Dw-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [Aw-1:0] addr;
  logic [Dw-1:0] data;
  logic          error;
  logic          error2;

  logic          halt, restore_we, done;
  logic [Aw-1:0] restore_addr;
  logic [Dw-1:0] restore_data;
  logic [Ew-1:0] err_count;

  logic          halt2, restore_we2, done2;
  logic [Aw-1:0] restore_addr2;
  logic [Dw-1:0] restore_data2;
  logic [1:0]    err_count2;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic [Dw-1:0] model [2**Aw];

  always #5 clk = ~clk;

  rf_recovery_ctrl #(
    .ADDR_WIDTH    (Aw),
    .DATA_WIDTH    (Dw),
    .ERR_CNT_WIDTH (Ew)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .we_i            (we),
    .addr_i          (addr),
    .data_i          (data),
    .error_i         (error),
    .halt_o          (halt),
    .restore_we_o    (restore_we),
    .restore_addr_o  (restore_addr),
    .restore_data_o  (restore_data),
    .recovery_done_o (done),
    .err_count_o     (err_count)
  );

  rf_recovery_ctrl #(
    .ADDR_WIDTH    (Aw),
    .DATA_WIDTH    (Dw),
    .ERR_CNT_WIDTH (2)
  ) dut2 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .we_i            (we),
    .addr_i          (addr),
    .data_i          (data),
    .error_i         (error2),
    .halt_o          (halt2),
    .restore_we_o    (restore_we2),
    .restore_addr_o  (restore_addr2),
    .restore_data_o  (restore_data2),
    .recovery_done_o (done2),
    .err_count_o     (err_count2)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One full pass of the shadow image followed by the done pulse.
  task automatic push_recovery();
    for (int a = 0; a < 2**Aw; a++) begin
      q.push_back('{done: 1'b0, addr: Aw'(a), data: model[a]});
    end
    q.push_back('{done: 1'b1, addr: '0, data: '0});
  endtask

  // Apply inputs at a negedge; return at the next negedge, after one sampling edge.
  task automatic cyc(input logic w, input logic [Aw-1:0] a, input logic [Dw-1:0] d,
                     input logic e);
    we = w; addr = a; data = d; error = e;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (restore_we || done) begin
      if (q.size() == 0) begin
        check("unexpected_beat", {done, restore_we, restore_addr, restore_data}, 64'h0);
      end else begin
        e = q.pop_front();
        check("restore_beat", {done, restore_we, restore_addr, restore_data},
              {e.done, !e.done, e.addr, e.data});
      end
    end else begin
      check("idle_restore_bus", {restore_addr, restore_data}, 64'h0);
    end
  end

  initial begin
    for (int a = 0; a < 2**Aw; a++) model[a] = '0;
    rst_n = 1'b0; we = 1'b0; addr = '0; data = '0; error = 1'b0; error2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {halt, restore_we, restore_addr, restore_data, done, err_count}, 64'h0);
    rst_n = 1'b1;

    // Legal write, write to the hardwired-zero entry, then a write masked by a mismatch.
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    model[5] = 32'hDEAD_BEEF;
    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    push_recovery();
    cyc(1'b1, 5'd3, 32'h0000_1234, 1'b1);
    check("halt_after_error", {63'h0, halt}, 64'h1);
    check("err_count_1", {56'h0, err_count}, 64'd1);
    for (int k = 2; k <= 35; k++) begin
      // Writes presented during recovery must be ignored.
      if (k <= 33) cyc(1'b1, 5'd9, 32'h5555_5555, 1'b0);
      else         cyc(1'b0, 5'd0, 32'h0, 1'b0);
      check("halt_window_r1", {63'h0, halt}, {63'h0, (k <= 34)});
    end
    check("err_count_after_r1", {56'h0, err_count}, 64'd1);
    check("queue_drained_r1", 64'(q.size()), 64'd0);

    // Error held high through a whole recovery, then re-triggers in the first IDLE cycle.
    push_recovery();
    push_recovery();
    cyc(1'b0, 5'd0, 32'h0, 1'b1);
    check("err_count_2", {56'h0, err_count}, 64'd2);
    for (int k = 2; k <= 47; k++) begin
      cyc(1'b0, 5'd0, 32'h0, (k <= 36));
      if (k == 34) check("err_count_held", {56'h0, err_count}, 64'd2);
      if (k == 35) check("halt_idle_gap", {63'h0, halt}, 64'h0);
      if (k == 36) begin
        check("halt_retrigger", {63'h0, halt}, 64'h1);
        check("err_count_3", {56'h0, err_count}, 64'd3);
      end
    end
    check("restore_at_addr10", {58'h0, restore_we, restore_addr}, {58'h0, 1'b1, 5'd10});

    // Reset in the middle of the second replay.
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs",
          {halt, restore_we, restore_addr, restore_data, done, err_count}, 64'h0);
    check("aborted_beats_left", 64'(q.size()), 64'd22);
    q.delete();
    for (int a = 0; a < 2**Aw; a++) model[a] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Shadow must be cleared; a fresh write and recovery run normally.
    cyc(1'b1, 5'd12, 32'hCAFE_0001, 1'b0);
    model[12] = 32'hCAFE_0001;
    push_recovery();
    cyc(1'b0, 5'd0, 32'h0, 1'b1);
    check("halt_after_reset", {63'h0, halt}, 64'h1);
    check("err_count_restart", {56'h0, err_count}, 64'd1);
    for (int k = 2; k <= 35; k++) begin
      cyc(1'b0, 5'd0, 32'h0, 1'b0);
      check("halt_window_r3", {63'h0, halt}, {63'h0, (k <= 34)});
    end
    check("queue_drained_r3", 64'(q.size()), 64'd0);

    // Narrow counter saturates after five back-to-back recoveries.
    error2 = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 1)   check("cnt2_1", {62'h0, err_count2}, 64'd1);
      if (k == 36)  check("cnt2_2", {62'h0, err_count2}, 64'd2);
      if (k == 71)  check("cnt2_3", {62'h0, err_count2}, 64'd3);
      if (k == 106) check("cnt2_sat4", {62'h0, err_count2}, 64'd3);
      if (k == 160) check("cnt2_sat5", {62'h0, err_count2}, 64'd3);
      error2 = (k < 150);
    end
    check("dut1_quiet", {63'h0, halt}, 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_recovery_ctrl.md
RF_RECOVERY_CTRL -- requirements
Module: rf_recovery_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter ERR_CNT_WIDTH, default 8, error counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port we_i  input  1  agreed write enable from the lockstep write comparator.
REQ-007 SHALL have port addr_i  input  ADDR_WIDTH  agreed write address.
REQ-008 SHALL have port data_i  input  DATA_WIDTH  agreed write data.
REQ-009 SHALL have port error_i  input  1  comparator mismatch flag for the current cycle.
REQ-010 SHALL have port halt_o  output  1  stall request to both cores.
REQ-011 SHALL have port restore_we_o  output  1  write strobe into both cores' register files.
REQ-012 SHALL have port restore_addr_o  output  ADDR_WIDTH  restore address.
REQ-013 SHALL have port restore_data_o  output  DATA_WIDTH  restore data.
REQ-014 SHALL have port recovery_done_o  output  1  one-cycle pulse at end of recovery.
REQ-015 SHALL have port err_count_o  output  ERR_CNT_WIDTH  saturating count of detected errors.

Function
REQ-016 SHALL hold a shadow copy of 2**ADDR_WIDTH entries of DATA_WIDTH bits.
REQ-017 SHALL, in IDLE with we_i=1 and error_i=0, write data_i into shadow[addr_i] at the next edge.
REQ-018 SHALL ignore writes to address 0; shadow[0] SHALL always read 0.
REQ-019 SHALL never commit a write in a cycle where error_i=1, regardless of we_i.
REQ-020 SHALL implement FSM states IDLE, HALT, RESTORE, DONE.
REQ-021 SHALL transition IDLE->HALT on the edge that samples error_i=1; otherwise stay in IDLE.
REQ-022 SHALL transition HALT->RESTORE unconditionally after one cycle (pipeline drain).
REQ-023 SHALL, in RESTORE, step an address counter from 0 to 2**ADDR_WIDTH-1, one entry per cycle, with restore_we_o=1, restore_addr_o=counter, restore_data_o=shadow[counter].
REQ-024 SHALL transition RESTORE->DONE after the last address; the counter SHALL NOT wrap into another pass.
REQ-025 SHALL, in DONE, assert recovery_done_o for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive halt_o=1 in HALT, RESTORE and DONE; 0 in IDLE.
REQ-027 SHALL drive restore_we_o=0, restore_addr_o=0, restore_data_o=0 outside RESTORE.
REQ-028 SHALL ignore we_i, error_i and data inputs outside IDLE: no shadow write, no count change.
REQ-029 SHALL increment err_count_o by 1 on each IDLE->HALT transition, saturating at all-ones.
REQ-030 Latency: error_i sampled at edge t gives halt_o=1 from t+1, first restore write at t+2, recovery_done_o at t+2+2**ADDR_WIDTH, IDLE at t+3+2**ADDR_WIDTH.

Reset
REQ-031 SHALL, on rst_ni=0, asynchronously enter IDLE, clear the counter, shadow entries and err_count_o, and drive every output to 0.
REQ-032 SHALL abort any recovery in progress when reset asserts; no recovery_done_o pulse is produced.
REQ-033 SHALL resume normal IDLE operation on the first edge after rst_ni deasserts.

Structure
REQ-034 SHALL import state enum rf_rec_state_e and the default width constants from the shared package ft_pkg.
REQ-035 SHALL instantiate shadow storage as sub-module shadow_regfile: one write port, one combinational read port, asynchronous clear.

Verification
REQ-036 Write 0xDEADBEEF to addr 5 with error_i=0, then force error -> restore cycle for addr 5 shows restore_data_o=0xDEADBEEF; all other entries are 0.
REQ-037 we_i=1, addr 3, data 0x1234, error_i=1 -> shadow[3] unchanged (0), halt_o=1 next cycle, err_count_o=1.
REQ-038 Single error in IDLE -> exactly 32 restore_we_o cycles (addrs 0..31), recovery_done_o one cycle, halt_o low 35 cycles after the error edge.
REQ-039 Write 0xFFFFFFFF to addr 0, then recover -> restore_data_o=0 at addr 0.
REQ-040 error_i held high through an entire recovery -> err_count_o rises by 1 only; new recovery starts on the first IDLE cycle.
REQ-041 rst_ni low mid-RESTORE at addr 10 -> outputs 0 immediately, err_count_o=0, no recovery_done_o; with ERR_CNT_WIDTH=2, 5 errors -> err_count_o=3.
